// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: counters, syncs, data window and pulses.
// Define VGA_TIMING_TRISTATE_EN to make h_cnt/v_cnt tristate inouts.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int DISP_W   = 512,
   parameter int DISP_H   = 480,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CNT_W    = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic             h_sync,
   output logic             v_sync,
   output logic             d_out,
   output logic             d_out_b,
   output logic             line_start,
   output logic             frame_start,
`ifdef VGA_TIMING_TRISTATE_EN
   inout  wire  [CNT_W-1:0] h_cnt,
   inout  wire  [CNT_W-1:0] v_cnt
`else
   output logic [CNT_W-1:0] h_cnt,
   output logic [CNT_W-1:0] v_cnt
`endif
);

   localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(HT - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(VT - 1);
   localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CNT_W-1:0] WIN_W  = CNT_W'(DISP_W);
   localparam logic [CNT_W-1:0] WIN_H  = CNT_W'(DISP_H);

   logic [CNT_W-1:0] hc;
   logic [CNT_W-1:0] vc;
   logic [CNT_W-1:0] h_q;
   logic [CNT_W-1:0] v_q;
   logic             hs_on;
   logic             vs_on;
   logic             in_win;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hc <= '0;
         vc <= '0;
      end else if (en) begin
         if (hc == H_LAST) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
         end else begin
            hc <= hc + 1'b1;
         end
      end
   end

   always_comb begin
      hs_on  = (hc >= HS_BEG) && (hc < HS_END);
      vs_on  = (vc >= VS_BEG) && (vc < VS_END);
      in_win = (hc < WIN_W) && (vc < WIN_H);
   end

   // Outputs sample the pre-edge counters: one enabled cycle of latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_sync      <= !HS_POL;
         v_sync      <= !VS_POL;
         d_out       <= 1'b0;
         d_out_b     <= 1'b1;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         h_q         <= '0;
         v_q         <= '0;
      end else if (en) begin
         h_sync      <= hs_on ? HS_POL : !HS_POL;
         v_sync      <= vs_on ? VS_POL : !VS_POL;
         d_out       <= in_win;
         d_out_b     <= !in_win;
         line_start  <= (hc == '0);
         frame_start <= (hc == '0) && (vc == '0);
         h_q         <= in_win ? hc : '0;
         v_q         <= in_win ? vc : '0;
      end
   end

`ifdef VGA_TIMING_TRISTATE_EN
   assign h_cnt = d_out ? h_q : 'z;
   assign v_cnt = d_out ? v_q : 'z;
`else
   assign h_cnt = h_q;
   assign v_cnt = v_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: default instance plus an
// inverted-polarity instance with a short frame.
module tb_vga_timing_gen;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic en    = 1'b0;

   always #5 clk = ~clk;

   logic       a_hs, a_vs, a_d, a_db, a_ls, a_fs;
   logic [9:0] a_hcnt, a_vcnt;
   logic       b_hs, b_vs, b_d, b_db, b_ls, b_fs;
   logic [9:0] b_hcnt, b_vcnt;

   vga_timing_gen dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .h_sync(a_hs), .v_sync(a_vs), .d_out(a_d), .d_out_b(a_db),
      .line_start(a_ls), .frame_start(a_fs),
      .h_cnt(a_hcnt), .v_cnt(a_vcnt)
   );

   vga_timing_gen #(
      .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
      .DISP_H(4), .HS_POL(1'b1), .VS_POL(1'b1)
   ) dut_p (
      .clk(clk), .rst_n(rst_n), .en(en),
      .h_sync(b_hs), .v_sync(b_vs), .d_out(b_d), .d_out_b(b_db),
      .line_start(b_ls), .frame_start(b_fs),
      .h_cnt(b_hcnt), .v_cnt(b_vcnt)
   );

   typedef struct packed {
      logic       hs, vs, d, db, ls, fs;
      logic [9:0] hc, vc;
   } out_t;

   typedef struct packed {
      out_t a;
      out_t b;
   } pair_t;

   pair_t       q[$];
   pair_t       last;
   pair_t       exp;
   logic [51:0] got;
   int          vectors = 0;
   int          errors  = 0;
   int          hd, vd, hp, vp;

   assign got = {a_hs, a_vs, a_d, a_db, a_ls, a_fs, a_hcnt, a_vcnt,
                 b_hs, b_vs, b_d, b_db, b_ls, b_fs, b_hcnt, b_vcnt};

   function automatic out_t model(int hc, int vc, int ha, int hfp,
                                  int hsy, int hpol, int dw, int va,
                                  int vfp, int vsy, int vpol, int dh);
      out_t m;
      bit hin = (hc >= ha + hfp) && (hc < ha + hfp + hsy);
      bit vin = (vc >= va + vfp) && (vc < va + vfp + vsy);
      m.hs = hin ? (hpol != 0) : (hpol == 0);
      m.vs = vin ? (vpol != 0) : (vpol == 0);
      m.d  = (hc < dw) && (vc < dh);
      m.db = !m.d;
      m.ls = (hc == 0);
      m.fs = (hc == 0) && (vc == 0);
      m.hc = m.d ? 10'(hc) : 10'd0;
      m.vc = m.d ? 10'(vc) : 10'd0;
      return m;
   endfunction

   function automatic out_t rst_val(int hpol, int vpol);
      out_t m;
      m.hs = (hpol == 0);
      m.vs = (vpol == 0);
      m.d  = 1'b0;
      m.db = 1'b1;
      m.ls = 1'b0;
      m.fs = 1'b0;
      m.hc = '0;
      m.vc = '0;
      return m;
   endfunction

   // One clock: drive en, push the expected outputs, wait past the edge.
   task automatic step(input bit e);
      @(negedge clk);
      en = e;
      if (e) begin
         last.a = model(hd, vd, 640, 16, 96, 0, 512, 480, 10, 2, 0, 480);
         last.b = model(hp, vp, 640, 16, 96, 1, 512, 6, 2, 2, 1, 4);
         hd++;
         if (hd == 800) begin
            hd = 0;
            vd = (vd == 524) ? 0 : vd + 1;
         end
         hp++;
         if (hp == 800) begin
            hp = 0;
            vp = (vp == 11) ? 0 : vp + 1;
         end
      end
      q.push_back(last);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      en    = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      hd = 0; vd = 0; hp = 0; vp = 0;
      last = {rst_val(0, 0), rst_val(1, 1)};
      q.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      exp = {rst_val(0, 0), rst_val(1, 1)};
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL reset_async: got %h expected %h", got, exp);
      end
      en = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         vectors++;
         if (got !== exp) begin
            errors++;
            $display("FAIL reset_hold: got %h expected %h", got, exp);
         end
      end
      @(negedge clk);
      en    = 1'b0;
      rst_n = 1'b1;
      hd = 0; vd = 0; hp = 0; vp = 0;
      last = exp;
      q.delete();
      step(1'b1);
      exp = q.pop_front();
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL reset_first: got %h expected %h", got, exp);
      end
      vectors++;
      if ({a_d, a_ls, a_fs, b_fs} !== 4'b1111) begin
         errors++;
         $display("FAIL first_frame_start: got %b expected 1111",
                  {a_d, a_ls, a_fs, b_fs});
      end
   endtask

   task automatic test_line_timing();
      int first_low = 0, low = 0, dcnt = 0, hmax = 0, ls1 = 0, ls2 = 0;
      do_reset();
      for (int n = 1; n <= 1700; n++) begin
         step(1'b1);
         exp = q.pop_front();
         vectors++;
         if (got !== exp) begin
            errors++;
            if (errors < 20)
               $display("FAIL line_sb n=%0d: got %h expected %h",
                        n, got, exp);
         end
         if (n <= 800 && !a_hs) begin
            low++;
            if (first_low == 0) first_low = n;
         end
         if (n <= 800 && a_d) begin
            dcnt++;
            if (int'(a_hcnt) > hmax) hmax = int'(a_hcnt);
         end
         if (a_ls) begin
            if (ls1 == 0) ls1 = n;
            else if (ls2 == 0) ls2 = n;
         end
      end
      vectors++;
      if (first_low !== 657 || low !== 96) begin
         errors++;
         $display("FAIL hsync_window: got start %0d len %0d expected 657 96",
                  first_low, low);
      end
      vectors++;
      if (ls2 - ls1 !== 800) begin
         errors++;
         $display("FAIL line_period: got %0d expected 800", ls2 - ls1);
      end
      vectors++;
      if (dcnt !== 512 || hmax !== 511) begin
         errors++;
         $display("FAIL data_window: got %0d/%0d expected 512/511",
                  dcnt, hmax);
      end
   endtask

   task automatic test_frames();
      int fs[$];
      int vs_hi = 0, hs_hi = 0, first_hi = 0;
      do_reset();
      for (int n = 1; n <= 19201; n++) begin
         step(1'b1);
         exp = q.pop_front();
         vectors++;
         if (got !== exp) begin
            errors++;
            if (errors < 20)
               $display("FAIL frame_sb n=%0d: got %h expected %h",
                        n, got, exp);
         end
         if (b_fs) fs.push_back(n);
         if (n <= 19200 && b_vs) vs_hi++;
         if (n <= 800 && b_hs) begin
            hs_hi++;
            if (first_hi == 0) first_hi = n;
         end
      end
      vectors++;
      if (fs.size() != 3) begin
         errors++;
         $display("FAIL frame_count: got %0d expected 3", fs.size());
      end else begin
         vectors++;
         if (fs[1] - fs[0] != 9600 || fs[2] - fs[1] != 9600) begin
            errors++;
            $display("FAIL frame_period: got %0d %0d expected 9600",
                     fs[1] - fs[0], fs[2] - fs[1]);
         end
      end
      vectors++;
      if (vs_hi !== 3200) begin
         errors++;
         $display("FAIL vsync_len: got %0d expected 3200", vs_hi);
      end
      vectors++;
      if (hs_hi !== 96 || first_hi !== 657) begin
         errors++;
         $display("FAIL hsync_pol: got %0d@%0d expected 96@657",
                  hs_hi, first_hi);
      end
   endtask

   task automatic test_en_toggle();
      int hs_low = 0, ls_cnt = 0;
      do_reset();
      for (int n = 1; n <= 2000; n++) begin
         step(n % 2 == 1);
         exp = q.pop_front();
         vectors++;
         if (got !== exp) begin
            errors++;
            if (errors < 20)
               $display("FAIL en_sb n=%0d: got %h expected %h",
                        n, got, exp);
         end
         if (!a_hs) hs_low++;
         if (a_ls) ls_cnt++;
      end
      vectors++;
      if (hs_low !== 192) begin
         errors++;
         $display("FAIL en_hsync: got %0d expected 192", hs_low);
      end
      vectors++;
      if (ls_cnt !== 4) begin
         errors++;
         $display("FAIL en_line_start: got %0d expected 4", ls_cnt);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int n = 1; n <= 6300; n++) begin
         step(1'b1);
         exp = q.pop_front();
         vectors++;
         if (got !== exp) begin
            errors++;
            if (errors < 20)
               $display("FAIL pre_rst_sb n=%0d: got %h expected %h",
                        n, got, exp);
         end
      end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      exp = {rst_val(0, 0), rst_val(1, 1)};
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL async_mid: got %h expected %h", got, exp);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL async_hold: got %h expected %h", got, exp);
      end
      @(negedge clk);
      en    = 1'b0;
      rst_n = 1'b1;
      hd = 0; vd = 0; hp = 0; vp = 0;
      last = exp;
      q.delete();
      for (int n = 1; n <= 900; n++) begin
         step(1'b1);
         exp = q.pop_front();
         vectors++;
         if (got !== exp) begin
            errors++;
            if (errors < 20)
               $display("FAIL post_rst_sb n=%0d: got %h expected %h",
                        n, got, exp);
         end
         if (n == 1) begin
            vectors++;
            if ({a_fs, b_fs} !== 2'b11) begin
               errors++;
               $display("FAIL restart_frame_start: got %b expected 11",
                        {a_fs, b_fs});
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_line_timing();
      test_frames();
      test_en_toggle();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errors);
      $finish;
   end

endmodule
